spi_send_con: RTL and testbench
===============================

Name: spi_send_con

Overview:
- Transmit-side counterpart of the multi-line SPI-style receive link, for the sensor/producer FPGA.
- Accepts a parallel word on a single-cycle trigger and serialises it MSB-first over LINES parallel data lines.
- Generates the data clock and the active-low chip select alongside the data.
- Its outputs drive the receiver's chip_data_in / chip_clk_in / chip_sel_in directly.

Parameters:
DATA_WIDTH, 8, bits per word; must be an integer multiple of LINES.
LINES, 4, number of parallel data lines; one symbol of LINES bits per data-clock period.
DATA_CLK_PERIOD, 6, system clocks per data-clock period; must be >= 2, even preferred.

Ports:
clk_in  input  1  system clock (100 MHz); the only clock.
rst_in  input  1  synchronous, active-high reset.
data_in  input  DATA_WIDTH  word to send; sampled only on an accepted trigger.
trigger_in  input  1  single-cycle start request; accepted only in IDLE.
busy_out  output  1  high from the cycle after acceptance through the end of GAP.
done_out  output  1  one-cycle pulse on the last cycle of GAP.
chip_data_out  output  LINES  current symbol; bit LINES-1 carries the most significant bit of the symbol.
chip_clk_out  output  1  data clock; idle low.
chip_sel_out  output  1  chip select, active low; idle high.

Behaviour:
- Symbol count: SYMS = DATA_WIDTH/LINES.
- Counters:
  - period counter pc, range 0..DATA_CLK_PERIOD-1.
  - symbol counter sc, range 0..SYMS-1.
- All outputs are registered.
- Reset (any state, including mid-transfer), effective the next cycle: state=IDLE, chip_sel_out=1, chip_clk_out=0, chip_data_out=0, busy_out=0, done_out=0, counters=0. An aborted word is never resumed.
- IDLE:
  - chip_sel_out=1, chip_clk_out=0.
  - If trigger_in=1 at edge t: latch data_in into the shift register and go to TRANSMIT.
  - At t+1: chip_sel_out=0, chip_data_out=data_in[DATA_WIDTH-1 -: LINES], pc=0, sc=0, busy_out=1.
- TRANSMIT:
  - chip_clk_out=1 when pc >= DATA_CLK_PERIOD/2 (integer floor), else 0.
  - Data changes only while the data clock is low: on the pc wrap, i.e. the edge where pc goes DATA_CLK_PERIOD-1 -> 0.
  - This gives the receiver a rising edge mid-symbol with >= 1 clock of setup and hold.
  - On each pc wrap with sc < SYMS-1: shift left by LINES, present the next symbol, sc++.
  - On the pc wrap with sc = SYMS-1: go to GAP.
  - Duration: exactly SYMS*DATA_CLK_PERIOD cycles with chip_sel_out=0.
- GAP:
  - chip_sel_out=1, chip_clk_out=0, chip_data_out=0.
  - Lasts DATA_CLK_PERIOD cycles; busy_out stays 1.
  - done_out=1 on the final GAP cycle, then IDLE.
- trigger_in while busy_out=1 (TRANSMIT or GAP): ignored; not queued.
- trigger_in held continuously high: a new word is accepted on the first IDLE cycle.
  - Back-to-back frames: SYMS*P cycles CS-low, then P CS-high GAP cycles, then 1 IDLE cycle.
- Word-to-CS-low latency: 1 cycle. Acceptance to done_out: (SYMS+1)*DATA_CLK_PERIOD cycles.
- data_in changing after acceptance has no effect on the frame in flight.
- Exactly SYMS rising edges of chip_clk_out per frame. No chip_clk_out edges while chip_sel_out=1.

Decomposition:
- Shared package spi_con_pkg:
  - state enum {IDLE, TRANSMIT, GAP}.
  - SYMS computation helper function.
  - Default link constants DATA_WIDTH=8, LINES=4, DATA_CLK_PERIOD=6, shared with the receiver.
- No sub-module: the counters and shift register are small enough to stay inline.
- Add an elaboration-time assertion that DATA_WIDTH % LINES == 0 and DATA_CLK_PERIOD >= 2.

Test Plan:
- Defaults, data_in=8'hA5, 1-cycle trigger:
  - chip_sel_out low for 12 cycles starting 1 cycle after trigger.
  - chip_clk_out high on pc=3,4,5 of each period.
  - Values at the two rising edges: 4'hA, then 4'h5.
  - done_out pulses 18 cycles after trigger; busy_out falls on the following cycle.
- Trigger 8'h3C, then re-pulse trigger with 8'hFF at cycles 5 and 14 after the first:
  - Both ignored; only 3C transmitted (symbols 3, C).
  - No second frame appears.
- trigger_in held high with data_in=8'h81:
  - Repeated frames.
  - chip_sel_out pattern per frame: 12 low, 6 high in GAP, then 1 idle-high cycle.
- rst_in asserted at cycle 4 of a transfer:
  - Next cycle: chip_sel_out=1, chip_clk_out=0, chip_data_out=0, busy_out=0.
  - No done_out pulse.
  - A subsequent trigger sends a full, correct frame.
- LINES=1, DATA_WIDTH=8, DATA_CLK_PERIOD=4, data_in=8'h81:
  - 8 rising edges carrying 1,0,0,0,0,0,0,1.
  - chip_sel_out low for 32 cycles.
- Loopback into the receiver (defaults), sending 8'h00, 8'hFF, 8'h5A:
  - Receiver asserts data_valid with 8'h00, 8'hFF, 8'h5A, in order, once each.

Source files
------------

// File: rtl/spi_con_pkg.sv
// spi_con_pkg: link types, default constants and helpers shared by the SPI-style send and receive sides
package spi_con_pkg;
  localparam int DEF_DATA_WIDTH      = 8;
  localparam int DEF_LINES           = 4;
  localparam int DEF_DATA_CLK_PERIOD = 6;
  typedef enum logic [1:0] {IDLE, TRANSMIT, GAP} state_e;
  function automatic int syms(input int data_width, input int lines);
    return data_width / lines;
  endfunction
endpackage

// File: rtl/spi_send_con.sv
// spi_send_con: serialises a parallel word MSB-first over LINES data lines with data clock and active-low select
//   clk_in/rst_in : system clock, synchronous active-high reset
//   data_in       : word latched on an accepted trigger_in (only in IDLE)
//   busy_out      : high from the cycle after acceptance through the end of the gap
//   done_out      : one-cycle pulse on the last gap cycle
//   chip_*_out    : registered link outputs (symbol, data clock idle low, select idle high)
module spi_send_con
  import spi_con_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int LINES           = DEF_LINES,
  parameter int DATA_CLK_PERIOD = DEF_DATA_CLK_PERIOD
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  trigger_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic [LINES-1:0]      chip_data_out,
  output logic                  chip_clk_out,
  output logic                  chip_sel_out
);
  localparam int SYMS = syms(DATA_WIDTH, LINES);
  localparam int PW = $clog2(DATA_CLK_PERIOD);
  localparam int SW = SYMS > 1 ? $clog2(SYMS) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(DATA_CLK_PERIOD - 1);
  localparam logic [PW-1:0] P_HALF = PW'(DATA_CLK_PERIOD / 2);
  localparam logic [SW-1:0] S_LAST = SW'(SYMS - 1);
  if (DATA_WIDTH % LINES != 0 || DATA_CLK_PERIOD < 2) begin : g_param_check
    $error("spi_send_con: DATA_WIDTH must be a multiple of LINES and DATA_CLK_PERIOD >= 2");
  end
  state_e                  state_q;
  logic [PW-1:0]           pc_q, pc_d;
  logic [SW-1:0]           sc_q;
  logic [DATA_WIDTH-1:0]   sh_q, sh_d;
  logic                    sel_q, clk_q, busy_q, done_q;
  logic [LINES-1:0]        dat_q;
  assign pc_d = pc_q + PW'(1);
  assign sh_d = sh_q << LINES;
  assign busy_out      = busy_q;
  assign done_out      = done_q;
  assign chip_data_out = dat_q;
  assign chip_clk_out  = clk_q;
  assign chip_sel_out  = sel_q;
  // clk_q is loaded from the upcoming pc value so the registered clock lines up with pc;
  // symbols only change on the pc wrap, where the data clock is low.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      pc_q    <= '0;
      sc_q    <= '0;
      sh_q    <= '0;
      sel_q   <= 1'b1;
      clk_q   <= 1'b0;
      dat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (trigger_in) begin
          state_q <= TRANSMIT;
          sh_q    <= data_in;
          dat_q   <= data_in[DATA_WIDTH-1 -: LINES];
          sel_q   <= 1'b0;
          busy_q  <= 1'b1;
          pc_q    <= '0;
          sc_q    <= '0;
        end
        TRANSMIT: if (pc_q == P_LAST) begin
          pc_q  <= '0;
          clk_q <= 1'b0;
          if (sc_q == S_LAST) begin
            state_q <= GAP;
            sel_q   <= 1'b1;
            dat_q   <= '0;
          end else begin
            sh_q  <= sh_d;
            dat_q <= sh_d[DATA_WIDTH-1 -: LINES];
            sc_q  <= sc_q + SW'(1);
          end
        end else begin
          pc_q  <= pc_d;
          clk_q <= pc_d >= P_HALF;
        end
        GAP: if (pc_q == P_LAST) begin
          state_q <= IDLE;
          pc_q    <= '0;
          sc_q    <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end else begin
          pc_q   <= pc_d;
          done_q <= pc_d == P_LAST;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_send_con.sv
// tb_spi_send_con: directed self-checking bench for spi_send_con (defaults and a LINES=1 instance)
module tb_spi_send_con;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] d0 = '0, d1 = '0;
  logic trig0 = 1'b0, trig1 = 1'b0;
  logic busy0, done0, clk0, sel0, busy1, done1, clk1, sel1;
  logic [3:0] dat0;
  logic [0:0] dat1;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;

  spi_send_con u_dut0 (
    .clk_in(clk), .rst_in(rst), .data_in(d0), .trigger_in(trig0),
    .busy_out(busy0), .done_out(done0), .chip_data_out(dat0),
    .chip_clk_out(clk0), .chip_sel_out(sel0)
  );
  spi_send_con #(.DATA_WIDTH(8), .LINES(1), .DATA_CLK_PERIOD(4)) u_dut1 (
    .clk_in(clk), .rst_in(rst), .data_in(d1), .trigger_in(trig1),
    .busy_out(busy1), .done_out(done1), .chip_data_out(dat1),
    .chip_clk_out(clk1), .chip_sel_out(sel1)
  );

  // receiver model: captures a symbol on each data-clock rising edge while select is low
  logic [7:0] rsh0 = '0, rsh1 = '0;
  logic pclk0 = 1'b0, pclk1 = 1'b0;
  int rc0 = 0, rc1 = 0, edges0 = 0, edges1 = 0;
  logic [7:0] rxq0[$], rxq1[$];
  always @(negedge clk) begin
    if (rst || sel0) rc0 = 0;
    else if (clk0 && !pclk0) begin
      rsh0 = {rsh0[3:0], dat0};
      edges0++;
      if (rc0 == 1) begin rxq0.push_back(rsh0); rc0 = 0; end
      else rc0++;
    end
    pclk0 = clk0;
    if (rst || sel1) rc1 = 0;
    else if (clk1 && !pclk1) begin
      rsh1 = {rsh1[6:0], dat1};
      edges1++;
      if (rc1 == 7) begin rxq1.push_back(rsh1); rc1 = 0; end
      else rc1++;
    end
    pclk1 = clk1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] o0;
    logic [4:0] o1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    o0 = {sel0, clk0, dat0, busy0, done0};
    o1 = {sel1, clk1, dat1, busy1, done1};
    n_cmp++;
    if (o0 !== 8'b10_0000_00) begin n_bad++; $display("FAIL reset0 got %b want 10000000", o0); end
    n_cmp++;
    if (o1 !== 5'b10_0_00) begin n_bad++; $display("FAIL reset1 got %b want 10000", o1); end
  endtask

  task automatic test_basic();
    logic [7:0] w = 8'hA5;
    logic [7:0] o, e;
    int pc, e0, q0;
    e0 = edges0;
    q0 = rxq0.size();
    d0 = w;
    trig0 = 1'b1;
    tick();
    trig0 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      pc = (k - 1) % 6;
      e = {k > 12, k <= 12 && pc >= 3, k <= 6 ? w[7:4] : k <= 12 ? w[3:0] : 4'h0, k <= 18, k == 18};
      o = {sel0, clk0, dat0, busy0, done0};
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL basic k=%0d got %b want %b", k, o, e); end
      tick();
    end
    n_cmp++;
    if (edges0 - e0 != 2) begin n_bad++; $display("FAIL basic_edges got %0d want 2", edges0 - e0); end
    n_cmp++;
    if (rxq0.size() != q0 + 1 || rxq0[rxq0.size()-1] !== 8'hA5) begin
      n_bad++; $display("FAIL basic_rx words %0d want %0d", rxq0.size() - q0, 1);
    end
  endtask

  task automatic test_ignore();
    logic [7:0] o, e;
    int pc, q0;
    q0 = rxq0.size();
    d0 = 8'h3C;
    trig0 = 1'b1;
    tick();
    trig0 = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      pc = (k - 1) % 6;
      e = {k > 12, k <= 12 && pc >= 3, k <= 6 ? 4'h3 : k <= 12 ? 4'hC : 4'h0, k <= 18, k == 18};
      o = {sel0, clk0, dat0, busy0, done0};
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL ignore k=%0d got %b want %b", k, o, e); end
      trig0 = (k == 5 || k == 14);
      if (trig0) d0 = 8'hFF;
      tick();
    end
    trig0 = 1'b0;
    n_cmp++;
    if (rxq0.size() != q0 + 1 || rxq0[rxq0.size()-1] !== 8'h3C) begin
      n_bad++; $display("FAIL ignore_rx words %0d want 1", rxq0.size() - q0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] o, e;
    int m, pc, q0;
    q0 = rxq0.size();
    d0 = 8'h81;
    trig0 = 1'b1;
    tick();
    for (int k = 1; k <= 38; k++) begin
      m = (k - 1) % 19;
      pc = m % 6;
      e = {m >= 12, m < 12 && pc >= 3, m < 6 ? 4'h8 : m < 12 ? 4'h1 : 4'h0, m < 18, m == 17};
      o = {sel0, clk0, dat0, busy0, done0};
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL b2b k=%0d got %b want %b", k, o, e); end
      if (k == 38) trig0 = 1'b0;
      tick();
    end
    n_cmp++;
    if ({sel0, busy0} !== 2'b10) begin n_bad++; $display("FAIL b2b_stop got %b want 10", {sel0, busy0}); end
    n_cmp++;
    if (rxq0.size() != q0 + 2 || rxq0[q0] !== 8'h81 || rxq0[q0+1] !== 8'h81) begin
      n_bad++; $display("FAIL b2b_rx words %0d want 2", rxq0.size() - q0);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] o;
    int dn, lo, dk, q0;
    d0 = 8'hA5;
    trig0 = 1'b1;
    tick();
    trig0 = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    o = {sel0, clk0, dat0, busy0, done0};
    n_cmp++;
    if (o !== 8'b10_0000_00) begin n_bad++; $display("FAIL midrst_state got %b want 10000000", o); end
    dn = 0;
    lo = 0;
    for (int k = 0; k < 20; k++) begin
      dn += int'(done0);
      lo += int'(!sel0);
      tick();
    end
    n_cmp++;
    if (dn != 0 || lo != 0) begin n_bad++; $display("FAIL midrst_quiet done=%0d cs_low=%0d want 0 0", dn, lo); end
    q0 = rxq0.size();
    d0 = 8'h5A;
    trig0 = 1'b1;
    tick();
    trig0 = 1'b0;
    lo = 0;
    dk = 0;
    for (int k = 1; k <= 20; k++) begin
      lo += int'(!sel0);
      if (done0) dk = k;
      tick();
    end
    n_cmp++;
    if (lo != 12 || dk != 18) begin n_bad++; $display("FAIL midrst_frame cs_low=%0d done_k=%0d want 12 18", lo, dk); end
    n_cmp++;
    if (rxq0.size() != q0 + 1 || rxq0[rxq0.size()-1] !== 8'h5A) begin
      n_bad++; $display("FAIL midrst_rx words %0d want 1", rxq0.size() - q0);
    end
  endtask

  task automatic test_lines1();
    logic [7:0] w = 8'h81;
    logic [4:0] o, e;
    int pc, s, e1, q1;
    e1 = edges1;
    q1 = rxq1.size();
    d1 = w;
    trig1 = 1'b1;
    tick();
    trig1 = 1'b0;
    for (int k = 1; k <= 38; k++) begin
      pc = (k - 1) % 4;
      s = k <= 32 ? (k - 1) / 4 : 0;
      e = {k > 32, k <= 32 && pc >= 2, k <= 32 ? w[7-s] : 1'b0, k <= 36, k == 36};
      o = {sel1, clk1, dat1, busy1, done1};
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL lines1 k=%0d got %b want %b", k, o, e); end
      tick();
    end
    n_cmp++;
    if (edges1 - e1 != 8) begin n_bad++; $display("FAIL lines1_edges got %0d want 8", edges1 - e1); end
    n_cmp++;
    if (rxq1.size() != q1 + 1 || rxq1[rxq1.size()-1] !== 8'h81) begin
      n_bad++; $display("FAIL lines1_rx words %0d want 1", rxq1.size() - q1);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] words[3] = '{8'h00, 8'hFF, 8'h5A};
    int q0, t;
    q0 = rxq0.size();
    for (int i = 0; i < 3; i++) begin
      d0 = words[i];
      trig0 = 1'b1;
      tick();
      trig0 = 1'b0;
      t = 0;
      while (!done0 && t < 40) begin tick(); t++; end
      n_cmp++;
      if (!done0) begin n_bad++; $display("FAIL loop_done word %0d got timeout want done", i); end
      tick();
      tick();
    end
    n_cmp++;
    if (rxq0.size() != q0 + 3) begin
      n_bad++; $display("FAIL loop_count got %0d want 3", rxq0.size() - q0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (rxq0[q0+i] !== words[i]) begin
          n_bad++; $display("FAIL loop_word %0d got %h want %h", i, rxq0[q0+i], words[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore();
    test_back_to_back();
    test_mid_reset();
    test_lines1();
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
